// File: rtl/sudoku_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sudoku_pkg
// Description : Board geometry and state/group encodings shared by the
//               sudoku checker files.
// Revision    : 1.0 - initial release
// ============================================================================
package sudoku_pkg;

    localparam int N      = 4;
    localparam int BOX    = 2;
    localparam int CELL_W = 3;
    localparam int AW     = $clog2(N * N);
    localparam int GW     = $clog2(N);

    typedef enum logic [1:0] {
        GRP_ROW = 2'd0,
        GRP_COL = 2'd1,
        GRP_BOX = 2'd2
    } grp_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sudoku_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : sudoku_checker_if
// Description : Check request / result handshake plus board RAM read port.
// Revision    : 1.0 - initial release
// ============================================================================
interface sudoku_checker_if;

    logic                              check_start;
    logic                              rd_en;
    logic [sudoku_pkg::AW-1:0]         rd_addr;
    logic [sudoku_pkg::CELL_W-1:0]     rd_data;
    logic                              busy;
    logic                              check_done;
    logic                              solved;

    // Master = controlling FSM together with the board RAM.
    modport master (
        output check_start,
        output rd_data,
        input  rd_en,
        input  rd_addr,
        input  busy,
        input  check_done,
        input  solved
    );

    modport slave (
        input  check_start,
        input  rd_data,
        output rd_en,
        output rd_addr,
        output busy,
        output check_done,
        output solved
    );

endinterface
`default_nettype wire

// File: rtl/sudoku_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : sudoku_addr_gen
// Description : Walks rows, then columns, then boxes, one cell per cycle, and
//               maps (group type, group, element) to a board address.
// Revision    : 1.0 - initial release
// ============================================================================
module sudoku_addr_gen
    import sudoku_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          i_clr,
    input  wire logic          i_adv,
    output logic [AW-1:0]      o_rd_addr,
    output logic               o_first,
    output logic               o_last,
    output logic               o_scan_end
);

    grp_t            r_grp;
    logic [GW-1:0]   r_g;
    logic [GW-1:0]   r_e;
    logic            w_e_last;
    logic            w_g_last;
    logic [GW-1:0]   w_row;
    logic [GW-1:0]   w_col;

    assign w_e_last   = (r_e == GW'(N - 1));
    assign w_g_last   = (r_g == GW'(N - 1));
    assign o_first    = (r_e == '0);
    assign o_last     = w_e_last;
    assign o_scan_end = (r_grp == GRP_BOX) && w_g_last && w_e_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grp <= GRP_ROW;
            r_g   <= '0;
            r_e   <= '0;
        end else if (i_clr) begin
            r_grp <= GRP_ROW;
            r_g   <= '0;
            r_e   <= '0;
        end else if (i_adv) begin
            if (w_e_last) begin
                r_e <= '0;
                if (w_g_last) begin
                    r_g <= '0;
                    case (r_grp)
                        GRP_ROW: r_grp <= GRP_COL;
                        GRP_COL: r_grp <= GRP_BOX;
                        default: r_grp <= GRP_ROW;
                    endcase
                end else begin
                    r_g <= r_g + GW'(1);
                end
            end else begin
                r_e <= r_e + GW'(1);
            end
        end
    end

    // Element index runs row-major inside a box; group index picks the box.
    always_comb begin
        w_row = r_g;
        w_col = r_e;
        case (r_grp)
            GRP_COL: begin
                w_row = r_e;
                w_col = r_g;
            end
            GRP_BOX: begin
                w_row = GW'((int'(r_g) / BOX) * BOX + int'(r_e) / BOX);
                w_col = GW'((int'(r_g) % BOX) * BOX + int'(r_e) % BOX);
            end
            default: begin
                w_row = r_g;
                w_col = r_e;
            end
        endcase
    end

    assign o_rd_addr = AW'(int'(w_row) * N + int'(w_col));

endmodule
`default_nettype wire

// File: rtl/sudoku_checker.sv
`default_nettype none
// ============================================================================
// Module      : sudoku_checker
// Description : Scans the board RAM and reports whether every row, column and
//               box holds each value 1..N exactly once.
//               Option macro CHECKER_EARLY_EXIT_EN: stop at the first bad cell.
// Revision    : 1.0 - initial release
// ============================================================================
module sudoku_checker
    import sudoku_pkg::*;
(
    input  wire logic         clka,
    input  wire logic         restart,
    sudoku_checker_if.slave   bus
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_start_d;
    logic            w_start;
    logic            w_scan;
    logic            r_vld;
    logic            r_first_d;
    logic            r_last_d;
    logic [N-1:0]    r_mask;
    logic [N-1:0]    w_base;
    logic [N-1:0]    w_bit;
    logic            r_fail;
    logic            r_solved;
    logic            w_range_bad;
    logic            w_dup;
    logic            w_cell_bad;
    logic            w_first;
    logic            w_last;
    logic            w_scan_end;
    logic [AW-1:0]   w_rd_addr;

    assign w_scan  = (r_state == SCAN);
    assign w_start = (r_state == IDLE) && bus.check_start && !r_start_d;

    sudoku_addr_gen u_addr_gen (
        .clk        (clka),
        .rst        (restart),
        .i_clr      (!w_scan),
        .i_adv      (w_scan),
        .o_rd_addr  (w_rd_addr),
        .o_first    (w_first),
        .o_last     (w_last),
        .o_scan_end (w_scan_end)
    );

    assign bus.rd_en      = w_scan;
    assign bus.rd_addr    = w_rd_addr;
    assign bus.busy       = (r_state != IDLE);
    assign bus.check_done = (r_state == DONE);
    assign bus.solved     = r_solved;

    always_ff @(posedge clka or posedge restart) begin
        if (restart) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = SCAN;
                end
            end
            SCAN: begin
`ifdef CHECKER_EARLY_EXIT_EN
                if (w_scan_end || w_cell_bad) begin
                    w_state_nxt = DRAIN;
                end
`else
                if (w_scan_end) begin
                    w_state_nxt = DRAIN;
                end
`endif
            end
            DRAIN:   w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Cell check against the seen mask of the current group.
    always_comb begin
        w_bit       = '0;
        w_range_bad = (bus.rd_data == '0) || (bus.rd_data > CELL_W'(N));
        if (!w_range_bad) begin
            w_bit = N'(1) << (bus.rd_data - CELL_W'(1));
        end
        w_base     = r_first_d ? '0 : r_mask;
        w_dup      = |(w_base & w_bit);
        w_cell_bad = r_vld && (w_range_bad || w_dup);
    end

    always_ff @(posedge clka or posedge restart) begin
        if (restart) begin
            r_start_d <= 1'b0;
            r_vld     <= 1'b0;
            r_first_d <= 1'b0;
            r_last_d  <= 1'b0;
            r_mask    <= '0;
            r_fail    <= 1'b0;
            r_solved  <= 1'b0;
        end else begin
            r_start_d <= bus.check_start;
            r_vld     <= w_scan;
            r_first_d <= w_first;
            r_last_d  <= w_last;

            if (r_vld) begin
                r_mask <= r_last_d ? '0 : (w_base | w_bit);
            end else if (r_state == IDLE) begin
                r_mask <= '0;
            end

            if (w_start) begin
                r_fail   <= 1'b0;
                r_solved <= 1'b0;
            end else if (w_cell_bad) begin
                r_fail <= 1'b1;
            end

            // The final cell is still in flight during DRAIN, so fold it in here.
            if (r_state == DRAIN) begin
                r_solved <= !(r_fail || w_cell_bad);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sudoku_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_sudoku_checker
// Description : Scoreboard bench for sudoku_checker with a 1-cycle board RAM.
//               Expected values follow CHECKER_EARLY_EXIT_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sudoku_checker;
    import sudoku_pkg::*;

    typedef struct {
        bit solved;
        int lat;
        int reads;
        bit full;
    } exp_t;

    localparam logic [63:0] B_SOLVED = 64'h1234_3412_2143_4321;
    localparam logic [63:0] B_LATIN  = 64'h1234_2341_3412_4123;
    localparam logic [63:0] B_HOLE   = 64'h1234_3412_2140_4321;
    localparam logic [63:0] B_BIG    = 64'h5234_3412_2143_4321;
    localparam logic [63:0] B_DUP    = 64'h1134_3412_2143_4321;

`ifdef CHECKER_EARLY_EXIT_EN
    localparam int L_LATIN = 38, R_LATIN = 36;
    localparam int L_HOLE  = 15, R_HOLE  = 13;
    localparam int L_BIG   = 4,  R_BIG   = 2;
    localparam int L_DUP   = 5,  R_DUP   = 3;
    localparam bit F_FAIL  = 1'b0;
`else
    localparam int L_LATIN = 50, R_LATIN = 48;
    localparam int L_HOLE  = 50, R_HOLE  = 48;
    localparam int L_BIG   = 50, R_BIG   = 48;
    localparam int L_DUP   = 50, R_DUP   = 48;
    localparam bit F_FAIL  = 1'b1;
`endif

    logic clka    = 1'b0;
    logic restart = 1'b1;

    sudoku_checker_if bus ();

    sudoku_checker dut (
        .clka    (clka),
        .restart (restart),
        .bus     (bus)
    );

    always #5 clka = ~clka;

    logic [CELL_W-1:0] ram [N*N];
    always @(posedge clka) begin
        if (bus.rd_en) bus.rd_data <= ram[bus.rd_addr];
    end

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   reads = 0;
    int   hist [N*N];
    int   done_pulses = 0;
    int   hbad;

    always @(posedge clka) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever a result is presented.
    always @(posedge clka) begin
        #1;
        if (!restart) begin
            if (bus.rd_en) begin
                reads++;
                hist[bus.rd_addr]++;
            end
            if (bus.check_done) begin
                done_pulses++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got check_done=1 expected no pending check (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("solved", int'(bus.solved), int'(e.solved));
                    chk("latency", cyc - start_cyc + 1, e.lat);
                    chk("reads", reads, e.reads);
                    if (e.full) begin
                        hbad = 0;
                        for (int i = 0; i < N*N; i++) if (hist[i] != 3) hbad++;
                        chk("cells_not_read_3x", hbad, 0);
                    end
                end
            end
        end
    end

    task automatic load(input logic [63:0] b);
        for (int i = 0; i < N*N; i++) ram[i] = CELL_W'(b[63-4*i -: 4]);
    endtask

    task automatic clear_counts();
        reads = 0;
        for (int i = 0; i < N*N; i++) hist[i] = 0;
    endtask

    task automatic wait_done(input int d0, input string name);
        int t;
        t = 0;
        while (done_pulses == d0 && t < 200) begin
            @(negedge clka);
            t++;
        end
        chk(name, done_pulses - d0, 1);
        if (done_pulses == d0) sb.delete();
    endtask

    task automatic do_check(input logic [63:0] b, input bit s, input int lat,
                            input int rd, input bit full, input string name);
        int d0;
        @(negedge clka);
        load(b);
        clear_counts();
        d0 = done_pulses;
        sb.push_back('{s, lat, rd, full});
        start_cyc = cyc + 1;
        bus.check_start = 1'b1;
        @(negedge clka);
        bus.check_start = 1'b0;
        wait_done(d0, name);
        repeat (3) @(negedge clka);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        bus.check_start = 1'b0;
        load(B_SOLVED);
        clear_counts();
        repeat (3) @(negedge clka);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_rd_en", int'(bus.rd_en), 0);
        chk("rst_rd_addr", int'(bus.rd_addr), 0);
        chk("rst_check_done", int'(bus.check_done), 0);
        chk("rst_solved", int'(bus.solved), 0);
        restart = 1'b0;
        repeat (2) @(negedge clka);

        do_check(B_SOLVED, 1'b1, 50, 48, 1'b1, "done_solved");
        chk("solved_holds", int'(bus.solved), 1);
        do_check(B_LATIN, 1'b0, L_LATIN, R_LATIN, F_FAIL, "done_latin");
        do_check(B_HOLE, 1'b0, L_HOLE, R_HOLE, F_FAIL, "done_hole");
        do_check(B_BIG, 1'b0, L_BIG, R_BIG, F_FAIL, "done_big");
        do_check(B_DUP, 1'b0, L_DUP, R_DUP, F_FAIL, "done_dup");

        // Level held for 200 cycles starts exactly one check.
        load(B_SOLVED);
        clear_counts();
        d0 = done_pulses;
        sb.push_back('{1'b1, 50, 48, 1'b1});
        start_cyc = cyc + 1;
        bus.check_start = 1'b1;
        repeat (200) @(negedge clka);
        chk("hold_one_check", done_pulses - d0, 1);
        chk("solved_after_hold", int'(bus.solved), 1);
        bus.check_start = 1'b0;
        repeat (2) @(negedge clka);

        // A new edge during busy is ignored.
        clear_counts();
        d0 = done_pulses;
        sb.push_back('{1'b1, 50, 48, 1'b1});
        start_cyc = cyc + 1;
        bus.check_start = 1'b1;
        repeat (10) @(negedge clka);
        bus.check_start = 1'b0;
        @(negedge clka);
        bus.check_start = 1'b1;
        repeat (100) @(negedge clka);
        chk("busy_edge_ignored", done_pulses - d0, 1);
        bus.check_start = 1'b0;
        repeat (2) @(negedge clka);

        // Restart in the middle of a scan.
        bus.check_start = 1'b1;
        @(negedge clka);
        bus.check_start = 1'b0;
        repeat (19) @(negedge clka);
        chk("busy_before_abort", int'(bus.busy), 1);
        restart = 1'b1;
        @(posedge clka);
        #1;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_rd_en", int'(bus.rd_en), 0);
        chk("abort_solved", int'(bus.solved), 0);
        chk("abort_check_done", int'(bus.check_done), 0);
        @(negedge clka);
        restart = 1'b0;
        @(negedge clka);
        do_check(B_SOLVED, 1'b1, 50, 48, 1'b1, "done_after_restart");

        repeat (5) @(negedge clka);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
